l1a_pattern_gen: RTL and testbench
==================================

# l1a_pattern_gen

Parametrised successor to the fixed-mode test L1A generator used in pixel-readout benches and self-test paths. It generates an L1A strobe in one of four modes: periodic, pseudo-random at a programmable rate, periodic burst, or single-shot. Every candidate trigger passes through a minimum-spacing trigger rule. The block counts issued and vetoed triggers so that benches and global readout can check accounting against hit and read counters.

## Interface
- `PERIOD_WIDTH`, 12: width of the `period` input and the internal period counter.
- `COUNT_WIDTH`, 32: width of `l1aCount` and `vetoCount`.
- `SEED`, 16'hACE1: value the LFSR loads at reset. Must be nonzero.

- `clk`  in  1  40 MHz clock. Everything is on the rising edge.
- `reset`  in  1  Synchronous, active-high reset.
- `dis`  in  1  1 = generator disabled.
- `mode`  in  2  Trigger mode: 00 periodic, 01 random, 10 burst, 11 single-shot.
- `period`  in  PERIOD_WIDTH  Period in cycles for modes 00 and 10. A value of 0 is treated as 1.
- `rate`  in  7  Random-mode threshold; probability per cycle is `rate`/128.
- `burstLen`  in  4  Candidates per burst in mode 10. A value of 0 is treated as 1.
- `minSpacing`  in  4  Minimum number of idle cycles required between two issued L1As.
- `fire`  in  1  Single-shot request in mode 11; acts on its rising edge.
- `L1A`  out  1  Registered one-cycle trigger strobe.
- `l1aCount`  out  COUNT_WIDTH  Number of issued L1As; saturating.
- `vetoCount`  out  COUNT_WIDTH  Number of candidates vetoed by the spacing rule; saturating.

## Operation
- **Candidate generation.** Each cycle, a candidate `cand` is evaluated combinationally from the current state and the current `mode`.
- **Mode 00 (periodic).**
  - `pcnt` counts 0 up to P-1 and wraps, where P = max(`period`, 1).
  - `cand` is 1 when `pcnt` == P-1.
  - P = 1 gives a candidate every cycle.
- **Mode 01 (random).**
  - The LFSR is a 16-bit Galois LFSR, taps x^16+x^14+x^13+x^11+1, shifting every cycle (including while `dis`=1).
  - `cand` = (`lfsr[6:0]` < `rate`).
  - `rate` = 0 never produces a candidate; `rate` = 127 produces one on 127/128 of cycles.
- **Mode 10 (burst).**
  - `pcnt` runs as in mode 00.
  - When `pcnt` == P-1, `bcnt` is loaded with B = max(`burstLen`, 1).
  - `cand` = (`bcnt` != 0), and `bcnt` decrements each cycle it is nonzero.
  - If B >= P, bursts merge into a continuous stream.
- **Mode 11 (single-shot).**
  - `fire` is registered each cycle.
  - `cand` = `fire` & ~`fire_q`.
  - A held-high `fire` gives exactly one candidate.
- **Spacing rule.**
  - `gap` is loaded with `minSpacing` when an L1A issues, and decrements to 0 otherwise.
  - A candidate with `gap` != 0 is vetoed and increments `vetoCount`.
  - A candidate with `gap` == 0 issues and increments `l1aCount`.
  - `minSpacing` = 0 disables the rule.
- **Disable (`dis` = 1).**
  - `cand` is forced to 0: no L1A issues and no veto is counted.
  - `pcnt` and `bcnt` are held at 0; `gap` continues to decrement.
  - Counters hold their values.
- **Mode change.** When `mode` differs from its registered copy, `pcnt`, `bcnt` and `fire_q` clear that cycle and no candidate is generated that cycle.
- **Saturation.** Each counter saturates at all-ones and never wraps.

## Timing
- **Reset values.** While `reset` = 1, on the next edge:
  - `L1A` = 0;
  - `l1aCount` = 0 and `vetoCount` = 0;
  - `pcnt`, `bcnt`, `gap` and `fire_q` = 0;
  - `lfsr` = `SEED`.
- **Reset mid-burst.** Reset mid-operation aborts any burst or spacing window immediately.
- **Latency.**
  - `L1A` asserts on the edge after the cycle in which `cand` is evaluated true with `gap` == 0.
  - The counters update on that same edge.
- **Periodic timing.** After reset deasserts in mode 00 with P = 4, the first `L1A` is high in cycle 4, counting the first cycle out of reset as cycle 1. After that, it is high every 4 cycles.
- **Spacing.** Two issued L1As are separated by at least `minSpacing` cycles with `L1A` = 0.
- **Simultaneous events.**
  - A candidate that arrives in the same cycle `gap` reaches 0 issues.
  - An L1A and a veto can never occur in the same cycle.
- **Live input changes.**
  - A change to `period` takes effect on the next wrap comparison.
  - A shorter `period` with `pcnt` >= the new P-1 continues counting up to the full-width wrap.
  - A change to `burstLen` takes effect at the next burst load.

## Test plan
- **Reset.** Assert `reset` for 3 cycles in any mode -> `L1A` = 0, both counts = 0, and the LFSR equals `SEED` on the first cycle after release.
- **Periodic with no veto.** Mode 00, `period` = 10, `minSpacing` = 0, run 1000 cycles -> 100 L1As exactly 10 cycles apart, `vetoCount` = 0.
- **Burst with spacing rule.** Mode 10, `period` = 20, `burstLen` = 4, `minSpacing` = 1 -> per period, L1A at burst cycles 1 and 3, `vetoCount` +2.
- **Random rate.** Mode 01, `rate` = 13, run 100000 cycles -> `l1aCount` within 10156 ± 3%, matching a reference LFSR model bit-exactly.
- **Single-shot.** Mode 11, hold `fire` high for 50 cycles, then pulse it twice 3 cycles apart with `minSpacing` = 5 -> 1 + 1 L1As, `vetoCount` = 1.
- **Disable and saturation.**
  - Assert `dis` mid-burst -> no L1A and counts frozen; after deassert, periodic phase restarts from `pcnt` = 0.
  - With `COUNT_WIDTH` = 4 and mode 00, `period` = 1 for 20 cycles -> `l1aCount` = 15 and holds there.

Source files
------------

// File: rtl/l1a_pattern_gen_if.sv
// Control and status bundle of the L1A pattern generator.
// The bench or host drives through master; the generator attaches as slave.
interface l1a_pattern_gen_if #(
    parameter int unsigned PERIOD_WIDTH = 12,
    parameter int unsigned COUNT_WIDTH  = 32
);
    logic                    dis;
    logic [1:0]              mode;
    logic [PERIOD_WIDTH-1:0] period;
    logic [6:0]              rate;
    logic [3:0]              burst_len;
    logic [3:0]              min_spacing;
    logic                    fire;
    logic                    l1a;
    logic [COUNT_WIDTH-1:0]  l1a_count;
    logic [COUNT_WIDTH-1:0]  veto_count;

    modport master (
        output dis, mode, period, rate, burst_len, min_spacing, fire,
        input  l1a, l1a_count, veto_count
    );

    modport slave (
        input  dis, mode, period, rate, burst_len, min_spacing, fire,
        output l1a, l1a_count, veto_count
    );
endinterface

// File: rtl/l1a_pattern_gen.sv
// L1A strobe generator: periodic, LFSR-random, burst or single-shot candidates,
// filtered by a minimum-spacing rule, with saturating issue and veto counters.
module l1a_pattern_gen #(
    parameter int unsigned PERIOD_WIDTH = 12,
    parameter int unsigned COUNT_WIDTH  = 32,
    parameter logic [15:0] SEED         = 16'hACE1
) (
    input  logic            clk_i,
    input  logic            reset_i,
    l1a_pattern_gen_if.slave bus
);
    typedef enum logic [1:0] {
        MODE_PERIODIC = 2'b00,
        MODE_RANDOM   = 2'b01,
        MODE_BURST    = 2'b10,
        MODE_SINGLE   = 2'b11
    } mode_e;

    // Galois form of x^16 + x^14 + x^13 + x^11 + 1, shifting right.
    localparam logic [15:0]             LFSR_TAPS = 16'hB400;
    localparam logic [PERIOD_WIDTH-1:0] P_ONE     = PERIOD_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0]  C_ONE     = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0]  C_MAX     = '1;

    mode_e                   mode_in, mode_q;
    logic [PERIOD_WIDTH-1:0] period_eff, pcnt_q, pcnt_d;
    logic [3:0]              burst_eff, bcnt_q, bcnt_d, gap_q, gap_d;
    logic                    fire_q, fire_d;
    logic [15:0]             lfsr_q, lfsr_d;
    logic                    l1a_q, l1a_d;
    logic [COUNT_WIDTH-1:0]  l1a_cnt_q, l1a_cnt_d, veto_cnt_q, veto_cnt_d;
    logic                    mode_chg, active, wrap, cand, issue, veto;

    assign mode_in = mode_e'(bus.mode);

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        period_eff = (bus.period == '0) ? P_ONE : bus.period;
        burst_eff  = (bus.burst_len == 4'd0) ? 4'd1 : bus.burst_len;
        mode_chg   = (mode_in != mode_q);
        active     = !bus.dis && !mode_chg;
        wrap       = (pcnt_q == period_eff - P_ONE);
        lfsr_d     = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);

        cand = 1'b0;
        if (active) begin
            unique case (mode_in)
                MODE_PERIODIC: cand = wrap;
                MODE_RANDOM:   cand = (lfsr_q[6:0] < bus.rate);
                MODE_BURST:    cand = (bcnt_q != 4'd0);
                MODE_SINGLE:   cand = bus.fire & ~fire_q;
            endcase
        end

        pcnt_d = '0;
        if (active && (mode_in == MODE_PERIODIC || mode_in == MODE_BURST)) begin
            pcnt_d = wrap ? '0 : pcnt_q + P_ONE;
        end

        bcnt_d = 4'd0;
        if (active && mode_in == MODE_BURST) begin
            if (wrap) begin
                bcnt_d = burst_eff;
            end else if (bcnt_q != 4'd0) begin
                bcnt_d = bcnt_q - 4'd1;
            end
        end

        fire_d = mode_chg ? 1'b0 : bus.fire;

        issue = cand && (gap_q == 4'd0);
        veto  = cand && (gap_q != 4'd0);
        l1a_d = issue;

        if (issue) begin
            gap_d = bus.min_spacing;
        end else if (gap_q != 4'd0) begin
            gap_d = gap_q - 4'd1;
        end else begin
            gap_d = 4'd0;
        end

        l1a_cnt_d  = (issue && l1a_cnt_q != C_MAX) ? l1a_cnt_q + C_ONE : l1a_cnt_q;
        veto_cnt_d = (veto && veto_cnt_q != C_MAX) ? veto_cnt_q + C_ONE : veto_cnt_q;
    end

    // NOTE: sequential state uses non-blocking assignments; reset is synchronous.
    always_ff @(posedge clk_i) begin
        mode_q <= mode_in;
        if (reset_i) begin
            pcnt_q     <= '0;
            bcnt_q     <= 4'd0;
            gap_q      <= 4'd0;
            fire_q     <= 1'b0;
            lfsr_q     <= SEED;
            l1a_q      <= 1'b0;
            l1a_cnt_q  <= '0;
            veto_cnt_q <= '0;
        end else begin
            pcnt_q     <= pcnt_d;
            bcnt_q     <= bcnt_d;
            gap_q      <= gap_d;
            fire_q     <= fire_d;
            lfsr_q     <= lfsr_d;
            l1a_q      <= l1a_d;
            l1a_cnt_q  <= l1a_cnt_d;
            veto_cnt_q <= veto_cnt_d;
        end
    end

    assign bus.l1a        = l1a_q;
    assign bus.l1a_count  = l1a_cnt_q;
    assign bus.veto_count = veto_cnt_q;
endmodule

// File: tb/tb_l1a_pattern_gen.sv
// Scoreboarded bench for l1a_pattern_gen: expected L1A values are queued as
// each cycle is driven and compared once the DUT has registered its output.
module tb_l1a_pattern_gen;
    localparam int unsigned PW = 12;
    localparam int unsigned CW = 32;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    logic exp_q[$];

    always #5 clk = ~clk;

    l1a_pattern_gen_if #(.PERIOD_WIDTH(PW), .COUNT_WIDTH(CW)) bus ();
    l1a_pattern_gen_if #(.PERIOD_WIDTH(PW), .COUNT_WIDTH(4))  sat_bus ();

    l1a_pattern_gen #(.PERIOD_WIDTH(PW), .COUNT_WIDTH(CW), .SEED(SEED)) dut (
        .clk_i  (clk),
        .reset_i(reset),
        .bus    (bus.slave)
    );

    l1a_pattern_gen #(.PERIOD_WIDTH(PW), .COUNT_WIDTH(4), .SEED(SEED)) dut_sat (
        .clk_i  (clk),
        .reset_i(reset),
        .bus    (sat_bus.slave)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock: queue the expected strobe, advance, then compare the DUT output.
    task automatic step(input string tag, input logic exp_l1a);
        logic e;
        exp_q.push_back(exp_l1a);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check(tag, bus.l1a, e);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        check("reset_l1a", bus.l1a, 1'b0);
        check("reset_l1a_count", bus.l1a_count, 0);
        check("reset_veto_count", bus.veto_count, 0);
        reset = 1'b0;
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        logic [15:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    initial begin
        logic [15:0] m_lfsr;
        int          m_cnt;

        reset           = 1'b1;
        bus.dis         = 1'b0;
        bus.mode        = 2'b00;
        bus.period      = PW'(4);
        bus.rate        = 7'd0;
        bus.burst_len   = 4'd0;
        bus.min_spacing = 4'd0;
        bus.fire        = 1'b0;
        sat_bus.dis         = 1'b0;
        sat_bus.mode        = 2'b00;
        sat_bus.period      = PW'(1);
        sat_bus.rate        = 7'd0;
        sat_bus.burst_len   = 4'd0;
        sat_bus.min_spacing = 4'd0;
        sat_bus.fire        = 1'b0;

        // Periodic, P = 4: first strobe after the 4th edge out of reset.
        do_reset();
        for (int e = 1; e <= 12; e++) step("per4_l1a", (e % 4) == 0);
        check("per4_count", bus.l1a_count, 3);

        // Periodic, P = 10, no spacing rule, 1000 cycles.
        bus.period = PW'(10);
        do_reset();
        for (int e = 1; e <= 1000; e++) step("per10_l1a", (e % 10) == 0);
        check("per10_count", bus.l1a_count, 100);
        check("per10_veto", bus.veto_count, 0);

        // Burst, P = 20, B = 4, spacing 1: strobes on burst cycles 1 and 3.
        bus.mode = 2'b10; bus.period = PW'(20); bus.burst_len = 4'd4; bus.min_spacing = 4'd1;
        do_reset();
        for (int e = 1; e <= 200; e++) step("burst_l1a", e > 20 && ((e % 20) == 1 || (e % 20) == 3));
        check("burst_count", bus.l1a_count, 18);
        check("burst_veto", bus.veto_count, 18);

        // Random, rate 13, against a reference LFSR starting from SEED.
        bus.mode = 2'b01; bus.rate = 7'd13; bus.min_spacing = 4'd0;
        do_reset();
        m_lfsr = SEED;
        m_cnt  = 0;
        for (int e = 1; e <= 20000; e++) begin
            logic x;
            x = (m_lfsr[6:0] < bus.rate);
            if (x) m_cnt++;
            step("rand_l1a", x);
            m_lfsr = lfsr_next(m_lfsr);
        end
        check("rand_count", bus.l1a_count, m_cnt);
        check("rand_veto", bus.veto_count, 0);
        bus.rate = 7'd0;
        for (int e = 1; e <= 100; e++) step("rand0_l1a", 1'b0);
        check("rand0_count", bus.l1a_count, m_cnt);

        // Single-shot: held fire gives one, two pulses 3 cycles apart give one plus a veto.
        bus.mode = 2'b11; bus.min_spacing = 4'd5;
        do_reset();
        bus.fire = 1'b1;
        for (int e = 1; e <= 50; e++) step("ss_hold_l1a", e == 1);
        bus.fire = 1'b0;
        for (int e = 1; e <= 5; e++) step("ss_idle_l1a", 1'b0);
        bus.fire = 1'b1; step("ss_p1_l1a", 1'b1);
        bus.fire = 1'b0; step("ss_gap_l1a", 1'b0); step("ss_gap_l1a", 1'b0);
        bus.fire = 1'b1; step("ss_p2_l1a", 1'b0);
        bus.fire = 1'b0;
        for (int e = 1; e <= 10; e++) step("ss_tail_l1a", 1'b0);
        check("ss_count", bus.l1a_count, 2);
        check("ss_veto", bus.veto_count, 1);

        // Disable mid-burst, then phase restart; then a mode change aborts a loaded burst.
        bus.mode = 2'b10; bus.period = PW'(20); bus.burst_len = 4'd4; bus.min_spacing = 4'd0;
        do_reset();
        for (int e = 1; e <= 22; e++) step("dis_pre_l1a", e == 21 || e == 22);
        bus.dis = 1'b1;
        for (int e = 1; e <= 10; e++) step("dis_on_l1a", 1'b0);
        check("dis_frozen_count", bus.l1a_count, 2);
        check("dis_frozen_veto", bus.veto_count, 0);
        bus.dis = 1'b0;
        for (int r = 1; r <= 40; r++) step("dis_post_l1a", r > 20 && (r % 20) >= 1 && (r % 20) <= 4);
        check("dis_post_count", bus.l1a_count, 6);
        bus.mode = 2'b00;
        for (int m = 1; m <= 21; m++) step("mchg_l1a", m == 21);
        check("mchg_count", bus.l1a_count, 7);

        // Saturation on the 4-bit counter instance: period 1 issues every cycle.
        bus.dis = 1'b1;
        do_reset();
        for (int e = 1; e <= 20; e++) step("sat_main_l1a", 1'b0);
        check("sat_count", sat_bus.l1a_count, 15);
        check("sat_veto", sat_bus.veto_count, 0);
        check("sat_l1a", sat_bus.l1a, 1'b1);
        for (int e = 1; e <= 5; e++) step("sat_main_l1a", 1'b0);
        check("sat_hold", sat_bus.l1a_count, 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
